multdiv_sched: RTL and testbench



---
 rtl/multdiv_sched_pkg.sv | 17 +
 rtl/multdiv_sched_lane_sel.sv | 50 +++++
 rtl/multdiv_sched.sv | 173 +++++++++++++++++
 tb/tb_multdiv_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_sched_pkg.sv
// Shared types and constants for the multiply/divide issue scheduler.
package multdiv_sched_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 5;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/multdiv_sched_lane_sel.sv
// Fixed-priority lane select: lane 0 (older) always wins, the loser is stalled.
module multdiv_lane_sel
    import multdiv_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic              accept,
    input  logic              req0_valid,
    input  logic              req0_is_div,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    input  logic              req1_is_div,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              sel_valid,
    output logic              sel,
    output logic              sel_is_div,
    output logic [DATA_W-1:0] sel_a,
    output logic [DATA_W-1:0] sel_b,
    output logic [TAG_W-1:0]  sel_tag,
    output logic              stall0,
    output logic              stall1
);

    logic [1:0] req_v;
    logic [1:0] stall_v;

    assign req_v      = {req1_valid, req0_valid};
    assign sel_valid  = req0_valid | req1_valid;
    assign sel        = req0_valid ? LANE0 : LANE1;
    assign sel_is_div = req0_valid ? req0_is_div : req1_is_div;
    assign sel_a      = req0_valid ? req0_a      : req1_a;
    assign sel_b      = req0_valid ? req0_b      : req1_b;
    assign sel_tag    = req0_valid ? req0_tag    : req1_tag;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stall
            assign stall_v[gi] = req_v[gi] & ~(accept & (sel == 1'(gi)));
        end
    endgenerate

    assign stall0 = stall_v[0];
    assign stall1 = stall_v[1];

endmodule

// File: rtl/multdiv_sched.sv
// Shares one iterative mult/div unit between two issue lanes: start pulse,
// wait for ready (or time out), then hold the tagged result until written back.
module multdiv_sched
    import multdiv_sched_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int TIMEOUT = 40
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req0_is_div,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    input  logic              req1_is_div,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    input  logic              flush,
    output logic              stall0,
    output logic              stall1,
    output logic [DATA_W-1:0] md_a,
    output logic [DATA_W-1:0] md_b,
    output logic              md_ctrl_mult,
    output logic              md_ctrl_div,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_rdy,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_result,
    output logic              wb_exception,
    output logic [TAG_W-1:0]  wb_tag,
    output logic              wb_lane,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic [TAG_W-1:0]  op_tag_q;
    logic              op_lane_q;
    logic [DATA_W-1:0] md_a_q;
    logic [DATA_W-1:0] md_b_q;
    logic              md_ctrl_mult_q;
    logic              md_ctrl_div_q;
    logic              wb_valid_q;
    logic [DATA_W-1:0] wb_result_q;
    logic              wb_exception_q;
    logic [TAG_W-1:0]  wb_tag_q;
    logic              wb_lane_q;

    logic              accept;
    logic              take;
    logic              sel_valid;
    logic              sel;
    logic              sel_is_div;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [TAG_W-1:0]  sel_tag;

    assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE && wb_ready)) && !flush;
    assign take   = accept && sel_valid;

    multdiv_lane_sel #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_lane_sel (
        .accept      (accept),
        .req0_valid  (req0_valid),
        .req0_is_div (req0_is_div),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_tag    (req0_tag),
        .req1_valid  (req1_valid),
        .req1_is_div (req1_is_div),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_tag    (req1_tag),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .sel_is_div  (sel_is_div),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .sel_tag     (sel_tag),
        .stall0      (stall0),
        .stall1      (stall1)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            tmo_cnt_q      <= '0;
            op_tag_q       <= '0;
            op_lane_q      <= 1'b0;
            md_a_q         <= '0;
            md_b_q         <= '0;
            md_ctrl_mult_q <= 1'b0;
            md_ctrl_div_q  <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_result_q    <= '0;
            wb_exception_q <= 1'b0;
            wb_tag_q       <= '0;
            wb_lane_q      <= 1'b0;
        end else begin
            md_ctrl_mult_q <= 1'b0;
            md_ctrl_div_q  <= 1'b0;
            if (flush) begin
                state_q    <= ST_IDLE;
                wb_valid_q <= 1'b0;
            end else if (take) begin
                state_q        <= ST_START;
                tmo_cnt_q      <= '0;
                op_tag_q       <= sel_tag;
                op_lane_q      <= sel;
                md_a_q         <= sel_a;
                md_b_q         <= sel_b;
                md_ctrl_mult_q <= !sel_is_div;
                md_ctrl_div_q  <= sel_is_div;
                wb_valid_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: ;
                    // A ready still high from the previous op is deliberately ignored here.
                    ST_START: state_q <= ST_BUSY;
                    ST_BUSY: begin
                        if (md_rdy) begin
                            wb_result_q    <= md_result;
                            wb_exception_q <= md_exception;
                            wb_tag_q       <= op_tag_q;
                            wb_lane_q      <= op_lane_q;
                            wb_valid_q     <= 1'b1;
                            state_q        <= ST_DONE;
                        end else if (tmo_cnt_q == TMO_LAST) begin
                            wb_result_q    <= '0;
                            wb_exception_q <= 1'b1;
                            wb_tag_q       <= op_tag_q;
                            wb_lane_q      <= op_lane_q;
                            wb_valid_q     <= 1'b1;
                            state_q        <= ST_DONE;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (wb_ready) begin
                            wb_valid_q <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign md_a         = md_a_q;
    assign md_b         = md_b_q;
    assign md_ctrl_mult = md_ctrl_mult_q;
    assign md_ctrl_div  = md_ctrl_div_q;
    assign wb_valid     = wb_valid_q;
    assign wb_result    = wb_result_q;
    assign wb_exception = wb_exception_q;
    assign wb_tag       = wb_tag_q;
    assign wb_lane      = wb_lane_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_sched.sv
// Directed bench for multdiv_sched; the bench itself plays the mult/div unit.
module tb_multdiv_sched;

    logic        clock;
    logic        reset_n;
    logic        req0_valid, req0_is_div;
    logic [31:0] req0_a, req0_b;
    logic [4:0]  req0_tag;
    logic        req1_valid, req1_is_div;
    logic [31:0] req1_a, req1_b;
    logic [4:0]  req1_tag;
    logic        flush;
    logic        stall0, stall1;
    logic [31:0] md_a, md_b;
    logic        md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_result;
    logic        md_exception, md_rdy;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_result;
    logic        wb_exception;
    logic [4:0]  wb_tag;
    logic        wb_lane;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    multdiv_sched #(.DATA_W(32), .TAG_W(5), .TIMEOUT(40)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req0_valid   (req0_valid),
        .req0_is_div  (req0_is_div),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_tag     (req0_tag),
        .req1_valid   (req1_valid),
        .req1_is_div  (req1_is_div),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_tag     (req1_tag),
        .flush        (flush),
        .stall0       (stall0),
        .stall1       (stall1),
        .md_a         (md_a),
        .md_b         (md_b),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_rdy       (md_rdy),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_result    (wb_result),
        .wb_exception (wb_exception),
        .wb_tag       (wb_tag),
        .wb_lane      (wb_lane),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic set_req0(input logic v, input logic d, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] t);
        req0_valid = v; req0_is_div = d; req0_a = a; req0_b = b; req0_tag = t;
    endtask

    task automatic set_req1(input logic v, input logic d, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] t);
        req1_valid = v; req1_is_div = d; req1_a = a; req1_b = b; req1_tag = t;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; wb_ready = 1'b0;
        md_result = '0; md_exception = 1'b0; md_rdy = 1'b0;
        set_req0(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        set_req1(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_ctrl_mult", md_ctrl_mult, 0);
        chk("rst_md_a", md_a, 0);
        chk("rst_wb_tag", wb_tag, 0);
        reset_n = 1'b1;
        step();

        // Lane 0 multiply 7*6, unit ready 32 cycles after the pulse
        set_req0(1'b1, 1'b0, 32'd7, 32'd6, 5'd3);
        #1 chk("t1_stall0", stall0, 0);
        step();
        req0_valid = 1'b0;
        chk("t1_pulse_mult", md_ctrl_mult, 1);
        chk("t1_pulse_div", md_ctrl_div, 0);
        chk("t1_md_a", md_a, 7);
        chk("t1_md_b", md_b, 6);
        chk("t1_busy", busy, 1);
        step();
        chk("t1_pulse_width", md_ctrl_mult, 0);
        repeat (30) step();
        chk("t1_no_wb_early", wb_valid, 0);
        md_rdy = 1'b1; md_result = 32'd42;
        step();
        md_rdy = 1'b0;
        chk("t1_wb_valid", wb_valid, 1);
        chk("t1_wb_result", wb_result, 42);
        chk("t1_wb_tag", wb_tag, 3);
        chk("t1_wb_lane", wb_lane, 0);
        chk("t1_wb_exc", wb_exception, 0);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("t1_wb_drop", wb_valid, 0);
        chk("t1_idle", busy, 0);

        // Both lanes request together: lane 0 div 100/7, lane 1 mult 3*5
        set_req0(1'b1, 1'b1, 32'd100, 32'd7, 5'd1);
        set_req1(1'b1, 1'b0, 32'd3, 32'd5, 5'd2);
        #1 chk("t2_stall0", stall0, 0);
        chk("t2_stall1", stall1, 1);
        step();
        req0_valid = 1'b0;
        chk("t2_pulse_div", md_ctrl_div, 1);
        chk("t2_md_a", md_a, 100);
        chk("t2_md_b", md_b, 7);
        #1 chk("t2_stall1_start", stall1, 1);
        step();
        md_rdy = 1'b1; md_result = 32'd14;
        step();
        md_rdy = 1'b0;
        chk("t2_wb0_result", wb_result, 14);
        chk("t2_wb0_lane", wb_lane, 0);
        chk("t2_wb0_tag", wb_tag, 1);
        chk("t2_stall1_done", stall1, 1);
        wb_ready = 1'b1;
        #1 chk("t2_stall1_release", stall1, 0);
        step();
        req1_valid = 1'b0; wb_ready = 1'b0;
        chk("t2_b2b_pulse", md_ctrl_mult, 1);
        chk("t2_b2b_md_a", md_a, 3);
        chk("t2_b2b_wb_drop", wb_valid, 0);
        step();
        md_rdy = 1'b1; md_result = 32'd15;
        step();
        md_rdy = 1'b0;
        chk("t2_wb1_valid", wb_valid, 1);
        chk("t2_wb1_result", wb_result, 15);
        chk("t2_wb1_lane", wb_lane, 1);
        chk("t2_wb1_tag", wb_tag, 2);

        // Backpressure: hold in DONE for 5 cycles with lane 0 waiting
        set_req0(1'b1, 1'b0, 32'd2, 32'd8, 5'd4);
        #1 chk("t3_stall0_bp", stall0, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_valid", wb_valid, 1);
            chk("t3_hold_result", wb_result, 15);
            chk("t3_hold_tag", wb_tag, 2);
            chk("t3_hold_stall0", stall0, 1);
        end
        wb_ready = 1'b1;
        #1 chk("t3_stall0_release", stall0, 0);
        step();
        req0_valid = 1'b0; wb_ready = 1'b0;
        chk("t3_next_pulse", md_ctrl_mult, 1);
        chk("t3_next_md_a", md_a, 2);
        step();
        md_rdy = 1'b1; md_result = 32'd16;
        step();
        md_rdy = 1'b0;
        chk("t3_wb_result", wb_result, 16);
        chk("t3_wb_tag", wb_tag, 4);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // Divide by zero reported by the unit
        set_req0(1'b1, 1'b1, 32'd9, 32'd0, 5'd9);
        step();
        req0_valid = 1'b0;
        chk("t4_pulse_div", md_ctrl_div, 1);
        step();
        md_rdy = 1'b1; md_exception = 1'b1; md_result = 32'hFFFF_FFFF;
        step();
        md_rdy = 1'b0; md_exception = 1'b0;
        chk("t4_wb_valid", wb_valid, 1);
        chk("t4_wb_exc", wb_exception, 1);
        chk("t4_wb_tag", wb_tag, 9);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // Flush in BUSY, then a late ready that must be ignored
        set_req1(1'b1, 1'b0, 32'd5, 32'd5, 5'd6);
        step();
        req1_valid = 1'b0;
        chk("t5_pulse", md_ctrl_mult, 1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_flush_busy", busy, 0);
        chk("t5_flush_wb", wb_valid, 0);
        repeat (2) step();
        md_rdy = 1'b1; md_result = 32'd25;
        step();
        md_rdy = 1'b0;
        chk("t5_late_rdy_wb", wb_valid, 0);
        chk("t5_late_rdy_busy", busy, 0);

        // Flush blocks an accept; stale ready in START is ignored
        set_req0(1'b1, 1'b0, 32'd4, 32'd4, 5'd7);
        flush = 1'b1;
        #1 chk("t5_flush_stall0", stall0, 1);
        step();
        flush = 1'b0;
        chk("t5_flush_no_accept", busy, 0);
        #1 chk("t5_accept_stall0", stall0, 0);
        step();
        req0_valid = 1'b0;
        chk("t5_new_pulse", md_ctrl_mult, 1);
        md_rdy = 1'b1; md_result = 32'd99;
        step();
        md_rdy = 1'b0;
        chk("t5_stale_rdy_wb", wb_valid, 0);
        chk("t5_stale_rdy_busy", busy, 1);
        step();
        chk("t5_busy_wait", wb_valid, 0);
        md_rdy = 1'b1; md_result = 32'd16;
        step();
        md_rdy = 1'b0;
        chk("t5_new_wb_valid", wb_valid, 1);
        chk("t5_new_wb_result", wb_result, 16);
        chk("t5_new_wb_tag", wb_tag, 7);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // Unit never responds: timeout after 40 BUSY cycles
        md_result = 32'hDEAD_BEEF;
        set_req0(1'b1, 1'b0, 32'd1, 32'd1, 5'd10);
        step();
        req0_valid = 1'b0;
        step();
        repeat (39) step();
        chk("t6_tmo_not_yet", wb_valid, 0);
        chk("t6_tmo_busy", busy, 1);
        step();
        chk("t6_tmo_valid", wb_valid, 1);
        chk("t6_tmo_exc", wb_exception, 1);
        chk("t6_tmo_result", wb_result, 0);
        chk("t6_tmo_tag", wb_tag, 10);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // Asynchronous reset in the middle of BUSY
        set_req0(1'b1, 1'b1, 32'd50, 32'd5, 5'd11);
        step();
        req0_valid = 1'b0;
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_md_a", md_a, 0);
        chk("t7_rst_wb_tag", wb_tag, 0);
        chk("t7_rst_wb_exc", wb_exception, 0);
        chk("t7_rst_wb_valid", wb_valid, 0);
        step();
        reset_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
